// File: rtl/clk_div_prog_if.sv
// Divisor handshake and divided-clock outputs of clk_div_prog.
// CLK_DIV_PROG_PERIOD_CNT_EN adds the period_cnt signal.
interface clk_div_prog_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             clk_out;
    logic             tick;
    logic [WIDTH-1:0] cur_div;
    logic             cfg_err;
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
    logic [15:0]      period_cnt;

    modport master (
        output div_in, div_valid,
        input  div_ready, clk_out, tick, cur_div, cfg_err, period_cnt
    );
    modport slave (
        input  div_in, div_valid,
        output div_ready, clk_out, tick, cur_div, cfg_err, period_cnt
    );
`else
    modport master (
        output div_in, div_valid,
        input  div_ready, clk_out, tick, cur_div, cfg_err
    );
    modport slave (
        input  div_in, div_valid,
        output div_ready, clk_out, tick, cur_div, cfg_err
    );
`endif
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free divisor update at period boundaries.
// Optional macro CLK_DIV_PROG_PERIOD_CNT_EN adds a 16-bit count of completed-period ticks.
module clk_div_prog #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    clk_div_prog_if.slave bus
);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] cnt_p0;
    logic [WIDTH-1:0] cur_div_p0;
    logic [WIDTH-1:0] pend_div_p0;
    logic             pend_vld_p0;
    logic             clk_out_p0;
    logic             tick_p0;
    logic             cfg_err_p0;

    logic             boundary;
    logic             illegal;
    logic             accept;
    logic [WIDTH-1:0] div_eff;
    logic [WIDTH-1:0] cnt_nxt;

    // High-phase length ceil(P/2), one bit wider so P = 2^WIDTH-1 cannot overflow.
    function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] p);
        logic [WIDTH:0] sum;
        sum = {1'b0, p} + {{WIDTH{1'b0}}, 1'b1};
        return sum >> 1;
    endfunction

    always_comb begin
        boundary = en && (cnt_p0 == (cur_div_p0 - ONE));
        illegal  = bus.div_valid && (bus.div_in < TWO);
        accept   = bus.div_valid && !pend_vld_p0 && !illegal;
        div_eff  = (boundary && pend_vld_p0) ? pend_div_p0 : cur_div_p0;
        cnt_nxt  = boundary ? '0 : (cnt_p0 + ONE);
    end

    // Stage p0: counter, divided clock, strobe and divisor bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0      <= RST_DIV - ONE;
            cur_div_p0  <= RST_DIV;
            pend_div_p0 <= '0;
            pend_vld_p0 <= 1'b0;
            clk_out_p0  <= 1'b0;
            tick_p0     <= 1'b0;
            cfg_err_p0  <= 1'b0;
        end else begin
            if (en) begin
                cnt_p0     <= cnt_nxt;
                clk_out_p0 <= ({1'b0, cnt_nxt} < high_len(div_eff));
            end
            tick_p0 <= boundary;
            // A divisor accepted on a boundary edge only becomes eligible at the next boundary.
            if (boundary && pend_vld_p0) begin
                cur_div_p0  <= pend_div_p0;
                pend_vld_p0 <= 1'b0;
            end
            if (accept) begin
                pend_div_p0 <= bus.div_in;
                pend_vld_p0 <= 1'b1;
            end
            if (illegal) begin
                cfg_err_p0 <= 1'b1;
            end
        end
    end

`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
    logic [15:0] period_cnt_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_p0 <= '0;
        end else if (boundary) begin
            period_cnt_p0 <= period_cnt_p0 + 16'd1;
        end
    end

    assign bus.period_cnt = period_cnt_p0;
`endif

    assign bus.div_ready = !pend_vld_p0;
    assign bus.clk_out   = clk_out_p0;
    assign bus.tick      = tick_p0;
    assign bus.cur_div   = cur_div_p0;
    assign bus.cfg_err   = cfg_err_p0;
endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized self-checking bench for clk_div_prog with a period-level reference model.
// Build with CLK_DIV_PROG_PERIOD_CNT_EN defined to also exercise period_cnt.
module tb_clk_div_prog;
    logic clk;
    logic rst;
    logic en;

    clk_div_prog_if #(.WIDTH(8)) bus ();

    clk_div_prog #(.WIDTH(8), .RESET_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current period, active period length,
    // a queue of accepted-but-not-yet-applied divisors, and the sticky error.
    int m_phase = 1;
    int m_len   = 2;
    int m_pend[$];
    int m_clk   = 0;
    int m_tick  = 0;
    int m_err   = 0;
    int m_ticks = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst === 1'b1) begin
                m_len   = 2;
                m_phase = m_len - 1;
                m_pend.delete();
                m_clk   = 0;
                m_tick  = 0;
                m_err   = 0;
                m_ticks = 0;
            end else begin
                int  d;
                bit  v, e, room, wrap;
                d    = int'(bus.div_in);
                v    = bus.div_valid;
                e    = en;
                room = (m_pend.size() == 0);
                wrap = e && (m_phase == m_len - 1);
                if (wrap && m_pend.size() != 0) m_len = m_pend.pop_front();
                if (e) begin
                    m_phase = wrap ? 0 : m_phase + 1;
                    m_clk   = (m_phase < (m_len + 1) / 2) ? 1 : 0;
                end
                m_tick = wrap ? 1 : 0;
                if (wrap) m_ticks = (m_ticks + 1) % 65536;
                if (v && d < 2) m_err = 1;
                else if (v && room) m_pend.push_back(d);
            end
        end
    end

    always @(negedge clk) begin
        chk("clk_out", int'(bus.clk_out), m_clk);
        chk("tick", int'(bus.tick), m_tick);
        chk("cur_div", int'(bus.cur_div), m_len);
        chk("div_ready", int'(bus.div_ready), (m_pend.size() == 0) ? 1 : 0);
        chk("cfg_err", int'(bus.cfg_err), m_err);
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
        chk("period_cnt", int'(bus.period_cnt), m_ticks);
`endif
    end

    task automatic wait_tick(input int limit);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.tick && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("wait_tick_bound", int'(bus.tick), 1);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int r;
        rst = 1'b1;
        en  = 1'b0;
        bus.div_valid = 1'b0;
        bus.div_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_clk_out", int'(bus.clk_out), 0);
        chk("rst_tick", int'(bus.tick), 0);
        chk("rst_cur_div", int'(bus.cur_div), 2);
        chk("rst_ready", int'(bus.div_ready), 1);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);

        // Release with default divisor 2
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rel_clk_out", int'(bus.clk_out), (i % 2 == 0) ? 1 : 0);
            chk("rel_tick", int'(bus.tick), (i % 2 == 0) ? 1 : 0);
            chk("rel_cur_div", int'(bus.cur_div), 2);
        end

        // Mid-period update to 5
        wait_tick(4);
        bus.div_in    = 8'd5;
        bus.div_valid = 1'b1;
        @(negedge clk);
        bus.div_valid = 1'b0;
        chk("upd_ready_low", int'(bus.div_ready), 0);
        chk("upd_cur_old", int'(bus.cur_div), 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("upd_clk_out", int'(bus.clk_out), (i % 5 < 3) ? 1 : 0);
            chk("upd_tick", int'(bus.tick), (i % 5 == 0) ? 1 : 0);
            chk("upd_cur_new", int'(bus.cur_div), 5);
            chk("upd_ready_high", int'(bus.div_ready), 1);
        end

        // Illegal divisor
        bus.div_in    = 8'd1;
        bus.div_valid = 1'b1;
        @(negedge clk);
        bus.div_valid = 1'b0;
        chk("ill_cfg_err", int'(bus.cfg_err), 1);
        chk("ill_cur_div", int'(bus.cur_div), 5);
        chk("ill_ready", int'(bus.div_ready), 1);
        wait_tick(10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick && n < 20);
        chk("ill_period", n, 5);
        chk("ill_cfg_sticky", int'(bus.cfg_err), 1);

        // Freeze at cnt=2 with P=5
        repeat (2) @(negedge clk);
        chk("frz_clk_before", int'(bus.clk_out), 1);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("frz_clk_held", int'(bus.clk_out), 1);
            chk("frz_tick", int'(bus.tick), 0);
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("frz_resume_tick", int'(bus.tick), (i == 2) ? 1 : 0);
        end

        // Reset with divisor 9 pending
        bus.div_in    = 8'd9;
        bus.div_valid = 1'b1;
        @(negedge clk);
        bus.div_valid = 1'b0;
        chk("pend_ready_low", int'(bus.div_ready), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_clk_out", int'(bus.clk_out), 0);
        chk("arst_ready", int'(bus.div_ready), 1);
        chk("arst_cur_div", int'(bus.cur_div), 2);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("arst_no_apply", int'(bus.cur_div), 2);
        end

        // Acceptance coinciding with a boundary waits one more period
        wait_tick(4);
        @(negedge clk);
        bus.div_in    = 8'd3;
        bus.div_valid = 1'b1;
        @(negedge clk);
        bus.div_valid = 1'b0;
        chk("bnd_tick", int'(bus.tick), 1);
        chk("bnd_cur_held", int'(bus.cur_div), 2);
        chk("bnd_ready_low", int'(bus.div_ready), 0);
        @(negedge clk);
        chk("bnd_cur_held2", int'(bus.cur_div), 2);
        @(negedge clk);
        chk("bnd_cur_applied", int'(bus.cur_div), 3);
        chk("bnd_ready_high", int'(bus.div_ready), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en            = ($urandom_range(0, 9) != 0);
            bus.div_valid = ($urandom_range(0, 3) == 0);
            r             = $urandom_range(0, 19);
            if (r == 0)      bus.div_in = 8'd0;
            else if (r == 1) bus.div_in = 8'd1;
            else if (r == 2) bus.div_in = 8'd255;
            else             bus.div_in = 8'($urandom_range(2, 9));
            if ($urandom_range(0, 299) == 0) pulse_rst();
        end
        bus.div_valid = 1'b0;
        en = 1'b1;

`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
        pulse_rst();
        repeat (131072) @(negedge clk);
        chk("period_cnt_wrap", int'(bus.period_cnt), 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of divisor and internal counter.
REQ-002 SHALL have parameter RESET_DIV, default 2, active divisor after reset (2 gives 25 MHz from the 50 MHz board clock); legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable; low freezes divider.
REQ-006 SHALL have port div_in  input  WIDTH  requested divisor P.
REQ-007 SHALL have port div_valid  input  1  div_in valid.
REQ-008 SHALL have port div_ready  output  1  block can accept a divisor.
REQ-009 SHALL have port clk_out  output  1  registered divided clock, period P clk cycles.
REQ-010 SHALL have port tick  output  1  one-cycle strobe on the cycle clk_out rises.
REQ-011 SHALL have port cur_div  output  WIDTH  divisor currently in effect.
REQ-012 SHALL have port cfg_err  output  1  sticky flag, illegal divisor offered.

Function
REQ-013 SHALL count cnt 0..P-1 on each clk edge with en=1, wrapping P-1 -> 0 (period boundary).
REQ-014 SHALL drive clk_out=1 while cnt < ceil(P/2), else 0; odd P: high one cycle longer than low.
REQ-015 SHALL assert tick for exactly the cycle in which cnt=0 and en=1.
REQ-016 SHALL accept a divisor on any edge with div_valid=1 and div_ready=1.
REQ-017 SHALL hold an accepted divisor in a one-entry pending register; div_ready=0 while pending is occupied.
REQ-018 SHALL apply pending P at the first boundary strictly after the acceptance edge; cur_div updates on that edge; div_ready returns to 1 on the same edge.
REQ-019 SHALL, when an acceptance edge coincides with a boundary, apply the value at the following boundary, never mid-period.
REQ-020 SHALL reject div_in values 0 and 1: no acceptance, cur_div unchanged, cfg_err set to 1 on that edge; div_ready unaffected.
REQ-021 SHALL clear cfg_err only by reset.
REQ-022 SHALL, with en=0, hold cnt and clk_out, drive tick=0, keep any pending divisor, and still accept a divisor if div_ready=1.
REQ-023 SHALL resume from the frozen cnt when en returns to 1, with no extra or lost cycles.
REQ-024 SHALL register all outputs; no combinational path from inputs to outputs except div_ready from internal state only.

Reset
REQ-025 SHALL, on rst=1 (asynchronous, any time including mid-period or with update pending), set cnt=P-1, clk_out=0, tick=0, cur_div=RESET_DIV, pending empty, div_ready=1, cfg_err=0.
REQ-026 SHALL, on the first clk edge with rst=0 and en=1, produce cnt=0, clk_out=1, tick=1.

Configuration
REQ-027 SHALL, with macro CLK_DIV_PROG_PERIOD_CNT_EN defined, add output period_cnt (16 bits), reset 0, incremented on every tick, wrapping 65535 -> 0.
REQ-028 SHALL, without CLK_DIV_PROG_PERIOD_CNT_EN, omit the period_cnt port and its logic; all other behaviour identical.

Verification
REQ-029 SHALL test reset release, defaults, en=1: clk_out 1,0,1,0...; tick on every other cycle; cur_div=2.
REQ-030 SHALL test divisor update mid-period: P=2, offer div_in=5 -> div_ready 0 until next boundary; then clk_out 1,1,1,0,0 repeating; cur_div=5.
REQ-031 SHALL test illegal divisor: div_in=1, div_valid=1 -> cfg_err=1 and stays 1; cur_div unchanged; output period unchanged.
REQ-032 SHALL test en low for 7 cycles at cnt=2 with P=5 -> clk_out held, tick=0; after en high, next tick exactly 3 enabled cycles later.
REQ-033 SHALL test rst asserted with divisor 9 pending -> immediate clk_out=0, div_ready=1, cur_div=2; pending value never applied.
REQ-034 SHALL test, with CLK_DIV_PROG_PERIOD_CNT_EN and P=2, 131072 cycles -> period_cnt wraps and reads 0.
